// File: rtl/pc_sequencer_if.sv
// Bundle of fetch handshake, decoder flags and next-PC mux signals around pc_sequencer.
// The master modport is the sequencer side; the slave modport is IMEM, decoder and mux.
interface pc_sequencer_if;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] ir;
  logic        is_exc;
  logic        is_eret;
  logic        is_jump;
  logic        is_branch;
  logic        br_taken;
  logic        stall;
  logic [31:0] next_pc;
  logic [31:0] pc;
  logic [1:0]  pcsource;
  logic        pc_we;
  logic        addr_err;
  logic [31:0] retire_cnt;

  modport master (
    output imem_req, ir, pc, pcsource, pc_we, addr_err, retire_cnt,
    input  imem_ack, imem_rdata, is_exc, is_eret, is_jump, is_branch, br_taken, stall, next_pc
  );

  modport slave (
    input  imem_req, ir, pc, pcsource, pc_we, addr_err, retire_cnt,
    output imem_ack, imem_rdata, is_exc, is_eret, is_jump, is_branch, br_taken, stall, next_pc
  );
endinterface

// File: rtl/pc_sequencer.sv
// Multi-cycle next-PC controller: FETCH -> DECODE -> UPDATE, owning PC, IR and the
// pcsource select of the external next-PC mux, with misaligned-target trapping.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter logic [1:0]  EXC_SEL  = 2'b11
) (
  input  logic                 clk,
  input  logic                 rst,
  pc_sequencer_if.master       io_bus
);

  typedef enum logic [1:0] {StFetch, StDecode, StUpdate} state_e;

  state_e      r_state, w_state_d;
  logic [31:0] r_pc, w_pc_d;
  logic [31:0] r_ir, w_ir_d;
  logic [31:0] r_retire_cnt, w_retire_cnt_d;
  logic [1:0]  r_pcsource, w_pcsource_d;
  logic        w_aligned;
  logic        w_trap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= StFetch;
      r_pc         <= RESET_PC;
      r_ir         <= 32'h0;
      r_pcsource   <= 2'b00;
      r_retire_cnt <= 32'h0;
    end else begin
      r_state      <= w_state_d;
      r_pc         <= w_pc_d;
      r_ir         <= w_ir_d;
      r_pcsource   <= w_pcsource_d;
      r_retire_cnt <= w_retire_cnt_d;
    end
  end

  assign w_aligned = (io_bus.next_pc[1:0] == 2'b00);
  // The vector path is exempt so a misaligned vector can never re-trap.
  assign w_trap    = (r_state == StUpdate) && !w_aligned && (r_pcsource != EXC_SEL);

  always_comb begin
    w_state_d      = r_state;
    w_pc_d         = r_pc;
    w_ir_d         = r_ir;
    w_pcsource_d   = r_pcsource;
    w_retire_cnt_d = r_retire_cnt;
    case (r_state)
      StFetch: begin
        if (io_bus.imem_ack) begin
          w_ir_d    = io_bus.imem_rdata;
          w_state_d = StDecode;
        end
      end
      StDecode: begin
        if (!io_bus.stall) begin
          if (io_bus.is_exc || io_bus.is_eret) begin
            w_pcsource_d = EXC_SEL;
          end else if (io_bus.is_jump) begin
            w_pcsource_d = 2'b10;
          end else if (io_bus.is_branch && io_bus.br_taken) begin
            w_pcsource_d = 2'b01;
          end else begin
            w_pcsource_d = 2'b00;
          end
          w_state_d = StUpdate;
        end
      end
      StUpdate: begin
        if (w_trap) begin
          w_pcsource_d = EXC_SEL;
        end else begin
          w_pc_d         = io_bus.next_pc;
          w_retire_cnt_d = r_retire_cnt + 32'd1;
          w_state_d      = StFetch;
        end
      end
      default: w_state_d = StFetch;
    endcase
  end

  assign io_bus.imem_req   = (r_state == StFetch);
  assign io_bus.pc_we      = (r_state == StUpdate);
  assign io_bus.addr_err   = w_trap;
  assign io_bus.ir         = r_ir;
  assign io_bus.pc         = r_pc;
  assign io_bus.pcsource   = r_pcsource;
  assign io_bus.retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: each UPDATE cycle is checked by a monitor against
// hand-computed entries queued by the stimulus, plus directed timing and reset checks.
module tb_pc_sequencer;

  typedef struct packed {
    logic [1:0]  src;
    logic        err;
    logic [31:0] pc;
    logic [31:0] cnt;
  } exp_t;

  logic clk;
  logic rst;
  logic [31:0] br_tgt;
  logic [31:0] jmp_tgt;
  logic [31:0] vec_tgt;
  exp_t sb[$];
  int n_vec;
  int n_err;

  pc_sequencer_if bus ();

  pc_sequencer dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the CPU's 4:1 next-PC mux.
  assign bus.next_pc = (bus.pcsource == 2'b00) ? bus.pc + 32'd4 :
                       (bus.pcsource == 2'b01) ? br_tgt :
                       (bus.pcsource == 2'b10) ? jmp_tgt : vec_tgt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.pc_we) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("upd_pcsource", {30'd0, bus.pcsource}, {30'd0, e.src});
          chk("upd_addr_err", {31'd0, bus.addr_err}, {31'd0, e.err});
          chk("upd_pc", bus.pc, e.pc);
          chk("upd_retire_cnt", bus.retire_cnt, e.cnt);
        end
      end
    end
  endtask

  task automatic run_until(input string name, input logic [31:0] target, input int budget,
                           output int cyc, output int errs);
    cyc  = 0;
    errs = 0;
    while (bus.retire_cnt !== target && cyc < budget) begin
      tick();
      cyc++;
      if (bus.addr_err) errs++;
    end
    chk(name, bus.retire_cnt, target);
  endtask

  task automatic set_dec(input logic exc, input logic jmp, input logic br, input logic tk);
    bus.is_exc    = exc;
    bus.is_eret   = 1'b0;
    bus.is_jump   = jmp;
    bus.is_branch = br;
    bus.br_taken  = tk;
  endtask

  initial begin
    int cyc;
    int errs;
    int req_cnt;
    int stall_we;
    int upd_cyc;
    int src_bad;

    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.stall      = 1'b0;
    set_dec(1'b0, 1'b0, 1'b0, 1'b0);
    br_tgt  = 32'h0;
    jmp_tgt = 32'h0;
    vec_tgt = 32'h0;
    fork
      monitor();
    join_none

    repeat (2) tick();
    chk("rst_pc", bus.pc, 32'h0040_0000);
    chk("rst_ir", bus.ir, 32'h0);
    chk("rst_pcsource", {30'd0, bus.pcsource}, 32'd0);
    chk("rst_pc_we", {31'd0, bus.pc_we}, 32'd0);
    chk("rst_addr_err", {31'd0, bus.addr_err}, 32'd0);
    chk("rst_retire_cnt", bus.retire_cnt, 32'd0);
    chk("rst_imem_req", {31'd0, bus.imem_req}, 32'd1);

    // Sequential fetch, no control flow.
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h2408_0001;
    sb.push_back('{src: 2'b00, err: 1'b0, pc: 32'h0040_0000, cnt: 32'd0});
    sb.push_back('{src: 2'b00, err: 1'b0, pc: 32'h0040_0004, cnt: 32'd1});
    rst = 1'b0;
    run_until("seq1_cnt", 32'd1, 20, cyc, errs);
    chk("seq1_cycles", cyc, 32'd3);
    chk("seq1_pc", bus.pc, 32'h0040_0004);
    chk("seq_ir", bus.ir, 32'h2408_0001);
    run_until("seq2_cnt", 32'd2, 20, cyc, errs);
    chk("seq2_cycles", cyc, 32'd3);
    chk("seq2_pc", bus.pc, 32'h0040_0008);

    // Priority: exception beats jump and taken branch.
    vec_tgt = 32'h8000_0180;
    br_tgt  = 32'h8000_0200;
    jmp_tgt = 32'h0040_0100;
    set_dec(1'b1, 1'b1, 1'b1, 1'b1);
    sb.push_back('{src: 2'b11, err: 1'b0, pc: 32'h0040_0008, cnt: 32'd2});
    run_until("prio_cnt", 32'd3, 20, cyc, errs);
    chk("prio_pc", bus.pc, 32'h8000_0180);
    set_dec(1'b0, 1'b0, 1'b1, 1'b0);
    sb.push_back('{src: 2'b00, err: 1'b0, pc: 32'h8000_0180, cnt: 32'd3});
    run_until("untaken_cnt", 32'd4, 20, cyc, errs);
    chk("untaken_pc", bus.pc, 32'h8000_0184);
    set_dec(1'b0, 1'b0, 1'b1, 1'b1);
    sb.push_back('{src: 2'b01, err: 1'b0, pc: 32'h8000_0184, cnt: 32'd4});
    run_until("taken_cnt", 32'd5, 20, cyc, errs);
    chk("taken_pc", bus.pc, 32'h8000_0200);
    set_dec(1'b0, 1'b1, 1'b1, 1'b1);
    sb.push_back('{src: 2'b10, err: 1'b0, pc: 32'h8000_0200, cnt: 32'd5});
    run_until("jump_cnt", 32'd6, 20, cyc, errs);
    chk("jump_pc", bus.pc, 32'h0040_0100);

    // Fetch wait of 4 cycles, then 3 stalled DECODE cycles; cycle 0 is FETCH entry.
    set_dec(1'b0, 1'b0, 1'b0, 1'b0);
    sb.push_back('{src: 2'b00, err: 1'b0, pc: 32'h0040_0100, cnt: 32'd6});
    req_cnt  = 0;
    stall_we = 0;
    upd_cyc  = -1;
    src_bad  = 0;
    for (int c = 0; c < 12; c++) begin
      bus.imem_ack = (c == 4);
      bus.stall    = (c >= 5 && c <= 7);
      #1;
      if (c < 9 && bus.imem_req) req_cnt++;
      if (bus.stall && bus.pc_we) stall_we++;
      if (bus.stall && bus.pcsource != 2'b10) src_bad++;
      if (bus.pc_we && upd_cyc < 0) upd_cyc = c;
      @(posedge clk);
      #1;
    end
    bus.stall    = 1'b0;
    bus.imem_ack = 1'b1;
    chk("wait_req_cycles", req_cnt, 32'd5);
    chk("stall_pc_we", stall_we, 32'd0);
    chk("stall_pcsource_hold", src_bad, 32'd0);
    chk("update_cycle", upd_cyc, 32'd9);
    chk("stall_cnt", bus.retire_cnt, 32'd7);
    chk("stall_pc", bus.pc, 32'h0040_0104);

    // Misaligned jump traps to the vector one cycle later.
    vec_tgt = 32'h0040_0004;
    jmp_tgt = 32'h0040_0102;
    set_dec(1'b0, 1'b1, 1'b0, 1'b0);
    sb.push_back('{src: 2'b10, err: 1'b1, pc: 32'h0040_0104, cnt: 32'd7});
    sb.push_back('{src: 2'b11, err: 1'b0, pc: 32'h0040_0104, cnt: 32'd7});
    run_until("mis_cnt", 32'd8, 20, cyc, errs);
    chk("mis_cycles", cyc, 32'd4);
    chk("mis_err_pulses", errs, 32'd1);
    chk("mis_pc", bus.pc, 32'h0040_0004);
    chk("mis_pcsource", {30'd0, bus.pcsource}, 32'd3);

    // Async reset while in UPDATE, no clock edge in between.
    set_dec(1'b0, 1'b0, 1'b0, 1'b0);
    cyc = 0;
    while (!bus.pc_we && cyc < 10) begin
      tick();
      cyc++;
    end
    chk("arst_reach_update", {31'd0, bus.pc_we}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("arst_pc", bus.pc, 32'h0040_0000);
    chk("arst_pc_we", {31'd0, bus.pc_we}, 32'd0);
    chk("arst_imem_req", {31'd0, bus.imem_req}, 32'd1);
    chk("arst_cnt", bus.retire_cnt, 32'd0);
    chk("arst_pcsource", {30'd0, bus.pcsource}, 32'd0);
    bus.imem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("arst_ack_ignored", bus.ir, 32'h0);
    rst = 1'b0;

    // Retire counter wrap.
    force dut.r_retire_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_retire_cnt;
    sb.push_back('{src: 2'b00, err: 1'b0, pc: 32'h0040_0000, cnt: 32'hFFFF_FFFF});
    run_until("wrap_cnt", 32'd0, 20, cyc, errs);
    chk("wrap_pc", bus.pc, 32'h0040_0004);

    chk("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Multi-cycle next-PC controller for the CPU-54 core. It owns the PC register and the fetch handshake to instruction memory. It drives the 2-bit pcsource select into the existing 4:1 next-PC mux and loads the mux result back into the PC. It also enforces jump priority, word alignment and retire counting.

Parameters:
RESET_PC, 32'h00400000, PC value after reset
EXC_SEL, 2'b11, pcsource code for the exception/eret vector input

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
imem_req  out  1  fetch request to instruction memory
imem_ack  in  1  IMEM accepts request, instruction valid this cycle
imem_rdata  in  32  instruction word from IMEM
ir  out  32  latched instruction register, feeds decoder
is_exc  in  1  decoder: syscall/break/taken trap
is_eret  in  1  decoder: eret
is_jump  in  1  decoder: j/jal/jr/jalr
is_branch  in  1  decoder: conditional branch
br_taken  in  1  ALU branch condition true
stall  in  1  hold in DECODE, e.g. multi-cycle mul/div busy
next_pc  in  32  output of the next-PC mux
pc  out  32  current PC
pcsource  out  2  mux select: 00 pc+4, 01 branch target, 10 jump target, 11 exception/eret vector
pc_we  out  1  PC load strobe
addr_err  out  1  one-cycle pulse: misaligned next_pc trapped
retire_cnt  out  32  count of PC updates

Behaviour:
- Reset (async, rst=1): state=FETCH, pc=RESET_PC, ir=0, pcsource=00, pc_we=0, addr_err=0, retire_cnt=0. imem_req asserts in the first cycle after rst deasserts.
- States:
  - FETCH: imem_req=1. On a clk edge with imem_ack=1: ir<=imem_rdata, go DECODE. Otherwise stay with imem_req held high.
  - DECODE: imem_req=0. Decoder inputs are valid combinationally from ir.
    - If stall=1: stay; pcsource keeps its previous value.
    - Else register pcsource by priority: is_exc or is_eret → 11; else is_jump → 10; else is_branch & br_taken → 01; else 00 (covers an untaken branch). Go UPDATE.
  - UPDATE: pcsource is stable from the previous edge and pc_we=1 (Moore, decoded from state).
    - If next_pc[1:0]==0, or pcsource==11: pc<=next_pc, retire_cnt<=retire_cnt+1 (wraps 0xFFFFFFFF→0), go FETCH.
    - Else (misaligned, pcsource≠11): PC not loaded, retire_cnt unchanged, pcsource<=11, addr_err=1 for exactly that cycle, stay in UPDATE one more cycle. That cycle loads the vector unconditionally, so the vector path cannot livelock.
- pc_we is high only in UPDATE. It is high in both UPDATE cycles of a trap sequence, but only the load edge changes pc.
- Latency: instruction with imem_ack in its first FETCH cycle and no stall takes 3 cycles FETCH→DECODE→UPDATE. A misaligned trap adds 1 cycle.
- rst asserted mid-operation (any state, including mid-handshake or mid-trap): immediate return to reset values. A pending imem_ack is ignored.
- stall sampled only in DECODE; ignored in FETCH/UPDATE.
- No combinational path from next_pc to pcsource (avoids loop through the mux).

Test Plan:
- Reset then sequential: rst pulse; imem_ack=1 every FETCH; decoder inputs all 0; next_pc=pc+4 → pc goes 0x00400000→0x00400004→0x00400008 at 3-cycle spacing; pcsource=00; retire_cnt=2.
- Priority: is_exc=1, is_jump=1, is_branch=1, br_taken=1 in one DECODE → pcsource=11; with only is_branch=1, br_taken=0 → pcsource=00.
- Fetch wait + stall: imem_ack low 4 cycles then high; stall high 3 cycles in DECODE → imem_req high exactly 5 cycles, pc_we never high during stall, UPDATE reached on cycle 9 after FETCH entry.
- Misaligned jump: is_jump=1, next_pc=0x00400102 → addr_err pulses 1 cycle, pcsource becomes 11, the vector next_pc=0x00400004 is loaded one cycle later, retire_cnt+1 only once.
- Async reset mid-UPDATE: assert rst between edges with pc_we=1 → pc=0x00400000, pc_we=0, state=FETCH immediately without a clk edge.
- Counter wrap: force retire_cnt=0xFFFFFFFF via one UPDATE → 0x00000000.
